// File: rtl/fp_acc_seq_if.sv
// Stream-side interface of the float accumulator sequencer: burst control,
// operand input stream and final-result output stream.
interface fp_acc_seq_if #(
    parameter int WIDTH = 27,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             out_ready;

    // Producer/consumer side (drives bursts and operands, takes the result).
    modport master (
        output start, count, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_err
    );

    // Accumulator side.
    modport slave (
        input  start, count, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/fp_acc_seq.sv
// Burst float accumulator sequencer. Sums N operands through one external
// fixed-latency adder, keeping the running sum and second operand in
// registers that feed the adder directly. Sign bits are stripped on entry
// and reported through a sticky error flag.
module fp_acc_seq #(
    parameter int WIDTH   = 27,
    parameter int CNT_W   = 8,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    fp_acc_seq_if.slave      bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum
);
    localparam int               WAIT_W    = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Operands are accumulated as magnitudes only.
    function automatic logic [WIDTH-1:0] clear_sign(input logic [WIDTH-1:0] x);
        return {1'b0, x[WIDTH-2:0]};
    endfunction

    state_t            state_r, state_s;
    logic [WIDTH-1:0]  acc_r, acc_s;
    logic [WIDTH-1:0]  opb_r, opb_s;
    logic [CNT_W-1:0]  rem_r, rem_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic [WIDTH-1:0]  out_data_r, out_data_s;
    logic              out_err_r, out_err_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              in_hs_s;

    assign in_hs_s       = bus.in_valid & in_ready_r;
    assign add_a         = acc_r;
    assign add_b         = opb_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;
    assign bus.busy      = busy_r;

    // Next-state and datapath update decisions.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        opb_s      = opb_r;
        rem_s      = rem_r;
        wait_s     = wait_r;
        out_data_s = out_data_r;
        out_err_s  = out_err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    out_err_s = 1'b0;
                    if (bus.count == CNT_ZERO) begin
                        out_data_s = DATA_ZERO;
                        state_s    = ST_DONE;
                    end else begin
                        rem_s   = bus.count - CNT_ONE;
                        state_s = ST_FIRST;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (in_hs_s) begin
                    acc_s     = clear_sign(bus.in_data);
                    out_err_s = out_err_r | bus.in_data[WIDTH-1];
                    if (rem_r == CNT_ZERO) begin
                        out_data_s = clear_sign(bus.in_data);
                        state_s    = ST_DONE;
                    end else begin
                        state_s = ST_ACCEPT;
                    end
                end else begin
                    state_s = ST_FIRST;
                end
            end
            ST_ACCEPT: begin
                if (in_hs_s) begin
                    opb_s     = clear_sign(bus.in_data);
                    out_err_s = out_err_r | bus.in_data[WIDTH-1];
                    state_s   = ST_ISSUE;
                end else begin
                    state_s = ST_ACCEPT;
                end
            end
            ST_ISSUE: begin
                // add_a/add_b are already stable; the adder samples them here.
                wait_s  = WAIT_INIT;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_r == {WAIT_W{1'b0}}) begin
                    acc_s = clear_sign(add_sum);
                    rem_s = rem_r - CNT_ONE;
                    if (rem_r == CNT_ONE) begin
                        out_data_s = clear_sign(add_sum);
                        state_s    = ST_DONE;
                    end else begin
                        state_s = ST_ACCEPT;
                    end
                end else begin
                    wait_s = wait_r - {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= DATA_ZERO;
            opb_r       <= DATA_ZERO;
            rem_r       <= CNT_ZERO;
            wait_r      <= {WAIT_W{1'b0}};
            out_data_r  <= DATA_ZERO;
            out_err_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            opb_r       <= opb_s;
            rem_r       <= rem_s;
            wait_r      <= wait_s;
            out_data_r  <= out_data_s;
            out_err_r   <= out_err_s;
            in_ready_r  <= (state_s == ST_FIRST) || (state_s == ST_ACCEPT);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end
endmodule

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
- Sequencer that sums a burst of N 27-bit floats (sign[26], expt[25:18], mant[17:0], implicit leading 1) from a valid/ready stream.
- Uses one external fp_addr instance, which has a fixed pipeline latency and no enable.
- Holds the running sum, drives the adder operands, and captures the adder result after ADD_LAT cycles.
- Presents the final sum on a valid/ready result port. It is the accumulation front end for per-body force summation in the grav_sim datapath.

Parameters:
- WIDTH, 27, float word width; field split fixed as above.
- CNT_W, 8, width of burst-length input; max N = 2^CNT_W-1.
- ADD_LAT, 1, adder latency in cycles, from operands stable at a clock edge to add_sum valid. Legal range 1..4.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
- start  input  1  begin burst; honoured only in IDLE.
- count  input  CNT_W  burst length N; captured with start.
- in_valid  input  1  operand valid.
- in_data  input  WIDTH  operand.
- in_ready  output  1  operand accepted when in_valid & in_ready.
- add_a  output  WIDTH  adder operand A; equals acc register.
- add_b  output  WIDTH  adder operand B; equals opb register.
- add_sum  input  WIDTH  adder result.
- busy  output  1  high in any state except IDLE.
- out_valid  output  1  result valid.
- out_data  output  WIDTH  final sum.
- out_err  output  1  sticky: some operand in burst had sign bit 1.
- out_ready  input  1  result consumed when out_valid & out_ready.

Behaviour:
- Reset (rst=0 at edge), from any state including mid-burst:
  - State goes to IDLE.
  - acc, opb, remaining count, wait counter, out_data all 0; out_err 0.
  - in_ready, out_valid, busy all 0.
  - Any partial sum is discarded.
- States: IDLE, FIRST, ACCEPT, ISSUE, WAIT, DONE.
- IDLE:
  - start=1, count=0 -> DONE with out_data=0, out_err=0.
  - start=1, count>0 -> FIRST with rem=count-1, out_err cleared.
  - start in any other state is ignored and not queued.
- FIRST:
  - in_ready=1. On handshake: acc <= in_data with bit26 forced 0; out_err |= in_data[26].
  - Then rem=0 -> DONE; otherwise -> ACCEPT.
- ACCEPT:
  - in_ready=1. On handshake: opb <= in_data with bit26 forced 0; out_err |= in_data[26]; -> ISSUE.
  - No handshake -> stay in ACCEPT, no timeout.
- ISSUE:
  - in_ready=0. add_a/add_b are already stable from registers; the adder captures them at this edge.
  - Wait counter <= ADD_LAT-1; -> WAIT.
- WAIT:
  - In the cycle where the wait counter = 0: acc <= add_sum with bit26 forced 0; rem <= rem-1; then rem-1=0 -> DONE, otherwise -> ACCEPT.
  - Otherwise decrement the wait counter.
- DONE:
  - out_valid=1; out_data=acc (or 0 for count=0). out_data and out_err stay stable while out_valid & !out_ready.
  - On handshake -> IDLE, out_valid drops next cycle.
- add_a/add_b are driven continuously from acc/opb. The adder computes every cycle; its output is used only in WAIT.
- Throughput:
  - 1 cycle for the first operand; 2+ADD_LAT cycles per further operand, with in_valid held high.
  - out_valid rises 2+(N-1)(2+ADD_LAT) cycles after the start cycle (11 for N=4, ADD_LAT=1).
- in_valid deasserted mid-burst stalls in FIRST/ACCEPT only; no other state depends on the input stream.
- No saturation or overflow detection: exponent wrap is inherited from the adder. Operand order into the adder is irrelevant because the adder picks the larger exponent.
- in_ready is high only in FIRST/ACCEPT. Data offered in other states is not consumed.

Test Plan:
- count=2, in_data 27'h1FC0000 (1.0), 27'h1FC0000 -> out_valid at cycle 5, out_data=27'h2000000 (2.0), out_err=0.
- count=4, four x 27'h1FC0000, in_valid held high -> intermediate acc 27'h2000000, 27'h2020000; out_valid at cycle 11, out_data=27'h2040000 (4.0).
- count=1, in_data=27'h5FC0000 (sign set) -> out_data=27'h1FC0000, out_err=1, no adder cycle used (out_valid at cycle 2).
- count=0 -> out_valid next cycle, out_data=0. Hold out_ready=0 for 5 cycles -> outputs stable, start pulses ignored, busy=1. Then out_ready=1 -> IDLE, busy=0.
- count=3 with in_valid gaps of 4 cycles between operands -> same sum as gap-free run; in_ready low in ISSUE/WAIT. Extra start pulses during the burst are ignored.
- rst=0 asserted in WAIT of a count=4 burst -> next cycle all outputs 0, state IDLE. A new count=2 burst then gives a clean 27'h2000000.
